// File: rtl/mem_stage_w.sv
// mem_stage_w: MIPS memory-access stage with byte-lane data memory and M/W pipeline register.
module mem_stage_w #(
    parameter int DM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_M,
    input  logic [31:0] PC8_M,
    input  logic [31:0] AO_M,
    input  logic [31:0] RT_M,
    input  logic [4:0]  A3_M,
    input  logic [2:0]  Res_M,
    input  logic [31:0] MD_hi_lo_M,
    output logic [31:0] IR_W,
    output logic [31:0] PC8_W,
    output logic [31:0] AO_W,
    output logic [31:0] DR_W,
    output logic [4:0]  A3_W,
    output logic [2:0]  Res_W,
    output logic [31:0] MD_hi_lo_W
);
    localparam int AW = $clog2(DM_WORDS);
    logic [31:0]   mem [DM_WORDS];
    logic [AW-1:0] idx;
    logic [5:0]    op;
    logic          is_sw, is_sh, is_sb;
    logic [3:0]    be;
    logic [31:0]   wdata, word, lane, dr;
    logic [15:0]   half;
    assign op    = IR_M[31:26];
    assign idx   = AO_M[AW+1:2];
    assign is_sw = op == 6'h2B;
    assign is_sh = op == 6'h29;
    assign is_sb = op == 6'h28;
    assign word  = mem[idx];
    assign half  = AO_M[1] ? word[31:16] : word[15:0];
    assign lane  = word >> {AO_M[1:0], 3'b000};
    always_comb begin
        be    = is_sw ? 4'hF : is_sh ? (AO_M[1] ? 4'hC : 4'h3) : is_sb ? 4'b0001 << AO_M[1:0] : 4'h0;
        wdata = is_sw ? RT_M : is_sh ? {2{RT_M[15:0]}} : {4{RT_M[7:0]}};
        dr    = op == 6'h23 ? word
              : op == 6'h21 ? {{16{half[15]}}, half}
              : op == 6'h25 ? {16'h0, half}
              : op == 6'h20 ? {{24{lane[7]}}, lane[7:0]}
              : op == 6'h24 ? {24'h0, lane[7:0]}
              : 32'h0;
    end
    // Reset clears the whole array so post-reset loads see zero memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) mem[i] <= 32'h0;
            IR_W       <= 32'h0;
            PC8_W      <= 32'h0;
            AO_W       <= 32'h0;
            DR_W       <= 32'h0;
            A3_W       <= 5'h0;
            Res_W      <= 3'h0;
            MD_hi_lo_W <= 32'h0;
        end else begin
            for (int k = 0; k < 4; k++) if (be[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
            IR_W       <= IR_M;
            PC8_W      <= PC8_M;
            AO_W       <= AO_M;
            DR_W       <= dr;
            A3_W       <= A3_M;
            Res_W      <= Res_M;
            MD_hi_lo_W <= MD_hi_lo_M;
        end
    end
endmodule

// File: tb/tb_mem_stage_w.sv
// tb_mem_stage_w: table-driven directed checks of loads, stores, wrap, and reset behaviour.
module tb_mem_stage_w;
    logic        clk = 0, reset = 1;
    logic [31:0] IR_M = 0, PC8_M = 0, AO_M = 0, RT_M = 0, MD_hi_lo_M = 0;
    logic [4:0]  A3_M = 0;
    logic [2:0]  Res_M = 0;
    logic [31:0] IR_W, PC8_W, AO_W, DR_W, MD_hi_lo_W;
    logic [4:0]  A3_W;
    logic [2:0]  Res_W;
    int checks = 0, errors = 0;

    mem_stage_w dut (
        .clk(clk), .reset(reset), .IR_M(IR_M), .PC8_M(PC8_M), .AO_M(AO_M), .RT_M(RT_M),
        .A3_M(A3_M), .Res_M(Res_M), .MD_hi_lo_M(MD_hi_lo_M), .IR_W(IR_W), .PC8_W(PC8_W),
        .AO_W(AO_W), .DR_W(DR_W), .A3_W(A3_W), .Res_W(Res_W), .MD_hi_lo_W(MD_hi_lo_W)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] LW = 6'h23, LH = 6'h21, LHU = 6'h25, LB = 6'h20, LBU = 6'h24;
    localparam logic [5:0] SW = 6'h2B, SH = 6'h29, SB = 6'h28, NOP = 6'h00, LUI = 6'h0F, SWL = 6'h2A;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] ao;
        logic [31:0] rt;
        logic [31:0] dr;
    } vec_t;
    vec_t v[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " IR_W"}, IR_W, 0);
        chk({nm, " PC8_W"}, PC8_W, 0);
        chk({nm, " AO_W"}, AO_W, 0);
        chk({nm, " DR_W"}, DR_W, 0);
        chk({nm, " A3_W"}, {27'h0, A3_W}, 0);
        chk({nm, " Res_W"}, {29'h0, Res_W}, 0);
        chk({nm, " MD_W"}, MD_hi_lo_W, 0);
    endtask

    task automatic step(input int n, input logic [5:0] op, input logic [31:0] ao, rt, dr, input string nm);
        logic [31:0] ir, pc8, md;
        logic [4:0]  a3;
        logic [2:0]  res;
        ir  = {op, 10'(n), 16'h1234};
        pc8 = 32'h0040_0000 + 32'(n) * 4;
        md  = ~ao ^ 32'(n);
        a3  = 5'(n + 1);
        res = 3'(n + 3);
        IR_M = ir; PC8_M = pc8; AO_M = ao; RT_M = rt; A3_M = a3; Res_M = res; MD_hi_lo_M = md;
        @(posedge clk);
        #1;
        chk({nm, " DR_W"}, DR_W, dr);
        chk({nm, " pass"}, {IR_W ^ PC8_W ^ AO_W ^ MD_hi_lo_W}, ir ^ pc8 ^ ao ^ md);
        chk({nm, " tags"}, {24'h0, A3_W, Res_W}, {24'h0, a3, res});
    endtask

    initial begin
        v.push_back('{SW,  32'h10,   32'h12345678, 32'h0});
        v.push_back('{LW,  32'h10,   32'h0,        32'h12345678});
        v.push_back('{LB,  32'h13,   32'h0,        32'h00000012});
        v.push_back('{LB,  32'h10,   32'h0,        32'h00000078});
        v.push_back('{SB,  32'h11,   32'hAAAA55F0, 32'h0});
        v.push_back('{LW,  32'h10,   32'h0,        32'h1234F078});
        v.push_back('{LB,  32'h11,   32'h0,        32'hFFFFFFF0});
        v.push_back('{LBU, 32'h11,   32'h0,        32'h000000F0});
        v.push_back('{LH,  32'h11,   32'h0,        32'hFFFFF078});
        v.push_back('{LHU, 32'h12,   32'h0,        32'h00001234});
        v.push_back('{SH,  32'h22,   32'hFFFF8001, 32'h0});
        v.push_back('{LW,  32'h20,   32'h0,        32'h80010000});
        v.push_back('{LH,  32'h22,   32'h0,        32'hFFFF8001});
        v.push_back('{LHU, 32'h22,   32'h0,        32'h00008001});
        v.push_back('{SH,  32'h23,   32'h0000ABCD, 32'h0});
        v.push_back('{LW,  32'h20,   32'h0,        32'hABCD0000});
        v.push_back('{LHU, 32'h23,   32'h0,        32'h0000ABCD});
        v.push_back('{LH,  32'h20,   32'h0,        32'h0});
        v.push_back('{SW,  32'h1004, 32'hCAFEBABE, 32'h0});
        v.push_back('{LW,  32'h4,    32'h0,        32'hCAFEBABE});
        v.push_back('{LH,  32'h6,    32'h0,        32'hFFFFCAFE});
        v.push_back('{LBU, 32'h4,    32'h0,        32'h000000BE});
        v.push_back('{LB,  32'hFFFF_F007, 32'h0,   32'hFFFFFFCA});
        v.push_back('{SW,  32'h3,    32'h01020304, 32'h0});
        v.push_back('{LW,  32'h1,    32'h0,        32'h01020304});
        v.push_back('{LUI, 32'h10,   32'hFFFFFFFF, 32'h0});
        v.push_back('{SWL, 32'h10,   32'hFFFFFFFF, 32'h0});
        v.push_back('{NOP, 32'h10,   32'hFFFFFFFF, 32'h0});
        v.push_back('{LW,  32'h10,   32'h0,        32'h1234F078});
        v.push_back('{LW,  32'hFFC,  32'h0,        32'h0});

        IR_M = {SW, 26'h0}; AO_M = 32'h8; RT_M = 32'hDEADBEEF; PC8_M = 32'h55; A3_M = 5'd7;
        Res_M = 3'd5; MD_hi_lo_M = 32'h77;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 0;
        step(100, LW, 32'h0, 32'h0, 32'h0, "first lw");
        step(101, LW, 32'h8, 32'h0, 32'h0, "sw under reset");

        foreach (v[i]) step(i, v[i].op, v[i].ao, v[i].rt, v[i].dr, $sformatf("vec%0d", i));

        IR_M = {SW, 26'h0}; AO_M = 32'h30; RT_M = 32'h87654321;
        reset = 1;
        @(posedge clk);
        #1;
        chk_zero("mid reset");
        reset = 0;
        step(200, LW, 32'h30, 32'h0, 32'h0, "post-reset store dropped");
        step(201, LW, 32'h10, 32'h0, 32'h0, "post-reset clear 10");
        step(202, LW, 32'h4,  32'h0, 32'h0, "post-reset clear 4");
        step(203, SB, 32'h33, 32'h000000C3, 32'h0, "sb lane3");
        step(204, LW, 32'h30, 32'h0, 32'hC3000000, "sb lane3 word");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage_w.md
# mem_stage_w

Memory-access stage of the five-stage MIPS pipeline: it takes the instruction held in the E/M register, performs the word, halfword or byte store into a 4 KB data memory, reads and sign- or zero-extends load data, and latches everything into the M/W pipeline register for write-back. It receives the M-side register outputs and hands W-side registered values to the write-back mux and the forwarding unit.

## Interface
- DM_WORDS, 1024, data-memory depth in 32-bit words; word index is AO_M[11:2]
- clk  input  1  clock; all state changes on posedge
- reset  input  1  reset, synchronous, active-high
- IR_M  input  32  instruction in M
- PC8_M  input  32  PC+8 of instruction in M
- AO_M  input  32  ALU result; effective address for loads/stores
- RT_M  input  32  store data, already forwarded
- A3_M  input  5  destination register number
- Res_M  input  3  result-source tag, passed through
- MD_hi_lo_M  input  32  HI/LO read value, passed through
- IR_W  output  32  registered IR_M
- PC8_W  output  32  registered PC8_M
- AO_W  output  32  registered AO_M
- DR_W  output  32  registered, extended load data; 0 for non-loads
- A3_W  output  5  registered A3_M
- Res_W  output  3  registered Res_M
- MD_hi_lo_W  output  32  registered MD_hi_lo_M

## Operation
- Decode IR_M[31:26]: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24, sw 0x2B, sh 0x29, sb 0x28. Any other opcode is a non-memory op: no write, DR load value 0.
- Index = AO_M[11:2]. AO_M[31:12] are ignored, so addresses wrap modulo 4 KB.
- Little-endian byte lanes: byte k = word[8k+7:8k], k = AO_M[1:0].
- sw: write all 4 lanes with RT_M. AO_M[1:0] is ignored.
- sh: AO_M[1]=0 writes lanes 1:0, AO_M[1]=1 writes lanes 3:2, using RT_M[15:0]. AO_M[0] is ignored.
- sb: write lane AO_M[1:0] with RT_M[7:0]. Other lanes are unchanged.
- Memory read is combinational from the current array contents at index.
- lw returns the word. lh/lhu return the halfword selected by AO_M[1], sign- or zero-extended to 32 bits. lb/lbu return the byte selected by AO_M[1:0], sign- or zero-extended.
- Misalignment is never trapped; the low bits are dropped as above.
- M/W register: on each posedge without reset, every *_W output takes its M input. DR_W takes the extended load value.

## Timing
- Store: array updated at the posedge where the store is in M. A load in M on the next cycle sees the new data.
- Load: data is read combinationally in M and registered into DR_W at the same edge. DR_W is valid one cycle after the load is in M; load-to-use latency is 1 cycle into W.
- There is no same-cycle read/write conflict, because one instruction is in M at a time.
- Reset, synchronous:
  - At a posedge with reset=1, all *_W outputs become 0.
  - Every memory word is cleared to 0.
  - A store present in M during that cycle is discarded; reset wins.
- Reset mid-stream: the first instruction after reset deasserts sees all-zero memory.
- No stall or flush inputs. Bubbles arrive as IR_M=0 (sll $0), which is a non-memory op and writes nothing.

## Test plan
- Reset then lw at AO=0x0 -> DR_W=0x00000000, and all *_W = 0 on the reset cycle.
- sw RT=0x12345678 at AO=0x10, then lw at 0x10 the next cycle -> DR_W=0x12345678. Then lb 0x13 -> 0x00000012, lb 0x10 -> 0x00000078.
- sb RT=0x000000F0 at 0x11 over word 0x12345678 -> word reads 0x1234F078. Then lb 0x11 -> 0xFFFFFFF0, lbu 0x11 -> 0x000000F0.
- sh RT=0x00008001 at 0x22 onto a zero word -> word 0x80010000. Then lh 0x22 -> 0xFFFF8001, lhu 0x22 -> 0x00008001. A misaligned sh at 0x23 behaves identically.
- sw RT=0xCAFEBABE at AO=0x00001004 -> lw at 0x4 returns 0xCAFEBABE (wrap check).
- sw asserted in the same cycle as reset -> lw of that address afterward returns 0. A non-memory op passes IR, PC8, AO, A3, Res and MD_hi_lo through with DR_W=0.
